// File: rtl/ram_sync_if.sv
// Request/response bundle between the datapath (master) and ram_sync (slave).
// Widths follow the RAM geometry parameters.
interface ram_sync_if #(
  parameter int WORD_SIZE   = 27,
  parameter int WORD_AMOUNT = 37
);
  localparam int AW = (WORD_AMOUNT > 1) ? $clog2(WORD_AMOUNT) : 1;

  logic [AW-1:0]        address;
  logic                 select;
  logic                 operation;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ready;
  logic [WORD_SIZE-1:0] rdata;
  logic                 valid;
  logic                 error;

  modport master (
    output address, select, operation, wdata,
    input  ready, rdata, valid, error
  );

  modport slave (
    input  address, select, operation, wdata,
    output ready, rdata, valid, error
  );
endinterface

// File: rtl/ram_sync.sv
// Synchronous single-port RAM: ready/valid handshake, response read_latency edges after accept,
// out-of-range flagging. Define RAM_ZERO_INIT_EN to zero the whole array after every reset.
module ram_sync #(
  parameter int word_size    = 27,
  parameter int word_amount  = 37,
  parameter int read_latency = 1
) (
  input logic       clk,
  input logic       rst,
  ram_sync_if.slave bus
);
  localparam int AW = (word_amount > 1) ? $clog2(word_amount) : 1;
  localparam int L  = read_latency;
  localparam logic [AW-1:0] LAST_ADDR = AW'(word_amount - 1);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic [2:0] {K_NONE, K_WR, K_RD, K_WR_ERR, K_RD_ERR} kind_t;

  state_t               state_q, state_d;
  kind_t                kind_d;
  kind_t                kind_q [L];
  logic [word_size-1:0] dat_q  [L];
  logic [word_size-1:0] mem    [word_amount];
  logic [word_size-1:0] rd_word;
  logic                 accept;
  logic                 in_range;

`ifdef RAM_ZERO_INIT_EN
  localparam int PW = $clog2(word_amount + 1);
  localparam logic [PW-1:0] SWEEP_END = PW'(word_amount);
  logic [PW-1:0] sweep_q, sweep_d;
  logic          sweep_we;
`endif

  function automatic logic is_read(kind_t k);
    return (k == K_RD) || (k == K_RD_ERR);
  endfunction

  always_comb begin
    state_d = state_q;
`ifdef RAM_ZERO_INIT_EN
    sweep_d  = sweep_q;
    sweep_we = 1'b0;
`endif
    case (state_q)
      INIT: begin
`ifdef RAM_ZERO_INIT_EN
        if (sweep_q == SWEEP_END) begin
          state_d = RUN;
        end else begin
          sweep_we = 1'b1;
          sweep_d  = sweep_q + PW'(1);
        end
`else
        state_d = RUN;
`endif
      end
      RUN: state_d = RUN;
    endcase
  end

  assign accept   = bus.select && (state_q == RUN);
  assign in_range = bus.address <= LAST_ADDR;
  assign rd_word  = in_range ? mem[bus.address] : '0;

  // Each pipeline slot carries the response kind; data slots only move for reads so rdata holds otherwise
  always_comb begin
    kind_d = K_NONE;
    if (accept) begin
      if (bus.operation) kind_d = in_range ? K_WR : K_WR_ERR;
      else               kind_d = in_range ? K_RD : K_RD_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      for (int i = 0; i < L; i++) begin
        kind_q[i] <= K_NONE;
        dat_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      kind_q[0] <= kind_d;
      if (is_read(kind_d)) dat_q[0] <= rd_word;
      for (int i = 1; i < L; i++) begin
        kind_q[i] <= kind_q[i-1];
        if (is_read(kind_q[i-1])) dat_q[i] <= dat_q[i-1];
      end
    end
  end

`ifdef RAM_ZERO_INIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sweep_q <= '0;
    else     sweep_q <= sweep_d;
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_q[AW-1:0]] <= '0;
    end else if (accept && bus.operation && in_range) begin
      mem[bus.address] <= bus.wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (accept && bus.operation && in_range) begin
      mem[bus.address] <= bus.wdata;
    end
  end
`endif

  assign bus.ready = (state_q == RUN);
  assign bus.valid = (kind_q[L-1] != K_NONE);
  assign bus.error = (kind_q[L-1] == K_WR_ERR) || (kind_q[L-1] == K_RD_ERR);
  assign bus.rdata = dat_q[L-1];
endmodule

// File: tb/tb_ram_sync.sv
// Drives one directed stimulus stream into three ram_sync instances (read_latency 1, 2, 3) and
// checks every cycle against a request-level model, plus literal expectations at key points.
module tb_ram_sync;
  localparam int WS = 27;
  localparam int WA = 37;
`ifdef RAM_ZERO_INIT_EN
  localparam int  INIT_EDGES = WA + 1;
  localparam bit  SWEEP      = 1'b1;
`else
  localparam int  INIT_EDGES = 1;
  localparam bit  SWEEP      = 1'b0;
`endif
  localparam int NREC = 4096;

  logic clk = 1'b0;
  logic rst;
  logic          sel;
  logic          opr;
  logic [5:0]    addr;
  logic [WS-1:0] wd;

  always #5 clk = ~clk;

  ram_sync_if #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) b1 ();
  ram_sync_if #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) b2 ();
  ram_sync_if #(.WORD_SIZE(WS), .WORD_AMOUNT(WA)) b3 ();

  assign b1.address = addr; assign b1.select = sel; assign b1.operation = opr; assign b1.wdata = wd;
  assign b2.address = addr; assign b2.select = sel; assign b2.operation = opr; assign b2.wdata = wd;
  assign b3.address = addr; assign b3.select = sel; assign b3.operation = opr; assign b3.wdata = wd;

  ram_sync #(.word_size(WS), .word_amount(WA), .read_latency(1)) u_l1 (.clk(clk), .rst(rst), .bus(b1));
  ram_sync #(.word_size(WS), .word_amount(WA), .read_latency(2)) u_l2 (.clk(clk), .rst(rst), .bus(b2));
  ram_sync #(.word_size(WS), .word_amount(WA), .read_latency(3)) u_l3 (.clk(clk), .rst(rst), .bus(b3));

  logic [2:0]    dut_ready, dut_valid, dut_err;
  logic [WS-1:0] dut_rdata [3];
  assign dut_ready = {b3.ready, b2.ready, b1.ready};
  assign dut_valid = {b3.valid, b2.valid, b1.valid};
  assign dut_err   = {b3.error, b2.error, b1.error};
  assign dut_rdata[0] = b1.rdata;
  assign dut_rdata[1] = b2.rdata;
  assign dut_rdata[2] = b3.rdata;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Request-level model: memory contents, and what each accept edge must eventually answer
  logic [WS-1:0] mem_val   [WA];
  logic          mem_known [WA];
  logic          acc_vld   [NREC];
  logic          acc_err   [NREC];
  logic          acc_rd    [NREC];
  logic [WS-1:0] acc_dat   [NREC];
  logic          acc_known [NREC];
  int            edge_n    = 0;
  int            rst_edge  = 0;
  int            since_rel = 0;
  logic [WS-1:0] rd_exp    [3];
  logic          rd_known  [3];

  initial begin
    for (int i = 0; i < WA; i++) begin
      mem_val[i]   = '0;
      mem_known[i] = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      since_rel = 0;
      rst_edge  = edge_n;
    end else if (edge_n < NREC - 1) begin
      edge_n++;
      acc_vld[edge_n]   = 1'b0;
      acc_err[edge_n]   = 1'b0;
      acc_rd[edge_n]    = 1'b0;
      acc_dat[edge_n]   = '0;
      acc_known[edge_n] = 1'b1;
      if (since_rel >= INIT_EDGES && sel) begin
        acc_vld[edge_n] = 1'b1;
        acc_err[edge_n] = (int'(addr) >= WA);
        acc_rd[edge_n]  = !opr;
        if (int'(addr) < WA) begin
          if (!opr) begin
            acc_dat[edge_n]   = mem_val[addr];
            acc_known[edge_n] = mem_known[addr];
          end else begin
            mem_val[addr]   = wd;
            mem_known[addr] = 1'b1;
          end
        end
      end
      since_rel++;
      if (SWEEP && since_rel >= 1 && since_rel <= WA) begin
        mem_val[since_rel-1]   = '0;
        mem_known[since_rel-1] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    int   a;
    logic ev, ee, er;
    for (int k = 0; k < 3; k++) begin
      a  = edge_n - k;
      ev = 1'b0;
      ee = 1'b0;
      if (rst) begin
        rd_exp[k]   = '0;
        rd_known[k] = 1'b1;
      end else if (a > rst_edge && a < NREC && acc_vld[a]) begin
        ev = 1'b1;
        ee = acc_err[a];
        if (acc_rd[a]) begin
          rd_exp[k]   = acc_dat[a];
          rd_known[k] = acc_known[a];
        end
      end
      er = !rst && (since_rel >= INIT_EDGES);
      chk($sformatf("L%0d ready", k + 1), 32'(dut_ready[k]), 32'(er));
      chk($sformatf("L%0d valid", k + 1), 32'(dut_valid[k]), 32'(ev));
      chk($sformatf("L%0d error", k + 1), 32'(dut_err[k]), 32'(ee));
      if (rd_known[k]) chk($sformatf("L%0d rdata", k + 1), 32'(dut_rdata[k]), 32'(rd_exp[k]));
    end
  end

  task automatic cyc(input logic s, input logic op, input int a, input int d);
    sel  = s;
    opr  = op;
    addr = a[5:0];
    wd   = d[WS-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  // Counts edges from now until ready is seen, bounded so a stuck DUT still reaches the summary
  task automatic measure_init(input string name);
    int cnt;
    cnt = 0;
    while (!dut_ready[0] && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(name, 32'(cnt), 32'(INIT_EDGES));
  endtask

  initial begin
    rst  = 1'b1;
    sel  = 1'b0;
    opr  = 1'b0;
    addr = '0;
    wd   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(dut_ready), 0);
    chk("reset valid", 32'(dut_valid), 0);
    chk("reset rdata", 32'(dut_rdata[2]), 0);

`ifdef RAM_ZERO_INIT_EN
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-sweep ready", 32'(dut_ready[0]), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif
    rst = 1'b0;
    chk("init ready low", 32'(dut_ready[0]), 0);
    measure_init("init edges");
`ifdef RAM_ZERO_INIT_EN
    cyc(1'b1, 1'b0, 5, 0);
    chk("sweep addr5", 32'(dut_rdata[0]), 0);
    chk("sweep addr5 valid", 32'(dut_valid[0]), 1);
`endif

    cyc(1'b1, 1'b1, 0, 7);
    cyc(1'b1, 1'b1, 20, 11);
    cyc(1'b1, 1'b1, 36, 134217727);
    cyc(1'b1, 1'b1, 3, 1234);
    chk("write resp valid", 32'(dut_valid[0]), 1);
    idle(1);
    cyc(1'b1, 1'b0, 0, 0);
    chk("rd0 valid", 32'(dut_valid[0]), 1);
    chk("rd0 data", 32'(dut_rdata[0]), 7);
    chk("rd0 error", 32'(dut_err[0]), 0);
    idle(1);
    chk("pulse low", 32'(dut_valid[0]), 0);
    chk("rdata hold", 32'(dut_rdata[0]), 7);
    cyc(1'b1, 1'b0, 20, 0);
    chk("rd20 data", 32'(dut_rdata[0]), 11);
    cyc(1'b1, 1'b0, 36, 0);
    chk("rd36 data", 32'(dut_rdata[0]), 134217727);
    idle(4);

    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 20, 0);
    chk("b2b L3 early", 32'(dut_valid[2]), 0);
    cyc(1'b1, 1'b0, 36, 0);
    chk("b2b L3 v1", 32'(dut_valid[2]), 1);
    chk("b2b L3 d1", 32'(dut_rdata[2]), 7);
    cyc(1'b1, 1'b0, 0, 0);
    chk("b2b L3 d2", 32'(dut_rdata[2]), 11);
    idle(1);
    chk("b2b L3 d3", 32'(dut_rdata[2]), 134217727);
    idle(1);
    chk("b2b L3 d4", 32'(dut_rdata[2]), 7);
    idle(1);
    chk("b2b L3 end", 32'(dut_valid[2]), 0);

    cyc(1'b1, 1'b1, 5, 42);
    cyc(1'b1, 1'b0, 5, 0);
    chk("raw data", 32'(dut_rdata[0]), 42);

    cyc(1'b1, 1'b1, 37, 5);
    chk("oor wr error", 32'(dut_err[0]), 1);
    cyc(1'b1, 1'b0, 37, 0);
    chk("oor rd error", 32'(dut_err[0]), 1);
    chk("oor rd data", 32'(dut_rdata[0]), 0);
    cyc(1'b1, 1'b0, 36, 0);
    chk("oor a36 kept", 32'(dut_rdata[0]), 134217727);
    chk("a36 error", 32'(dut_err[0]), 0);
    idle(3);

    cyc(1'b1, 1'b0, 20, 0);
    rst  = 1'b1;
    sel  = 1'b1;
    opr  = 1'b1;
    addr = 6'd3;
    wd   = 27'd99;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mid valid", 32'(dut_valid), 0);
    chk("rst mid rdata", 32'(dut_rdata[1]), 0);
    rst = 1'b0;
    measure_init("re-init edges");
    sel = 1'b0;
    chk("init sel no resp", 32'(dut_valid), 0);
    cyc(1'b1, 1'b0, 3, 0);
    chk("init sel ignored", 32'(dut_rdata[0]), SWEEP ? 0 : 1234);
    cyc(1'b1, 1'b0, 0, 0);
    chk("committed kept", 32'(dut_rdata[0]), SWEEP ? 0 : 7);
    idle(3);

    for (int i = 0; i < 30; i++) begin
      cyc(i % 5 != 4, i % 3 == 0, (i * 7) % 40, i * 1000 + 1);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
